// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and operation-mode encoding for the pipelined CLA adder/subtractor.
package pipelined_cla_adder_pkg;

  localparam int ALU_WIDTH       = 32;
  localparam int DEFAULT_GROUP_W = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } alu_mode_e;

  // Lookahead group sizes the carry network is built and timed for.
  function automatic bit legal_group_w(input int gw);
    return (gw == 2) || (gw == 4) || (gw == 8);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result valid-ready bus of the pipelined CLA adder; master = producer+consumer side.
interface pipelined_cla_adder_if
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_cla_adder_cla_group.sv
// W-bit carry-lookahead unit: carries into each bit from c_in, plus group propagate/generate.
module cla_group
  import pipelined_cla_adder_pkg::*;
#(
  parameter int W = DEFAULT_GROUP_W
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  input  logic         c_in,
  output logic [W-1:0] c,
  output logic         gp,
  output logic         gg
);

  // prop[i] = &p[i-1:0]; gen[i] = carry into bit i when c_in = 0
  logic [W:0] prop;
  logic [W:0] gen;

  always_comb begin : lookahead
    logic term;
    term    = 1'b0;
    prop    = '0;
    gen     = '0;
    prop[0] = 1'b1;
    for (int i = 1; i <= W; i++) begin
      prop[i] = prop[i-1] & p[i-1];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        gen[i] = gen[i] | term;
      end
    end
  end

  assign c  = gen[W-1:0] | (prop[W-1:0] & {W{c_in}});
  assign gp = prop[W];
  assign gg = gen[W];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with flags and valid/ready flow control.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int GROUP_W = DEFAULT_GROUP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int NG = WIDTH / GROUP_W;

  if (((WIDTH % GROUP_W) != 0) || !legal_group_w(GROUP_W)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH=%0d GROUP_W=%0d is not a supported combination",
           WIDTH, GROUP_W);
  end

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] p,
                                          input logic [GROUP_W-1:0] g);
    logic gen;
    gen = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      gen = g[i] | (p[i] & gen);
    end
    return {&p, gen};
  endfunction

  logic vld_p1;
  logic vld_p2;
  logic en_p1;
  logic en_p2;

  // A stage may load when it is empty or when the stage downstream is moving.
  assign en_p2         = !vld_p2 || bus.out_ready;
  assign en_p1         = !vld_p1 || en_p2;
  assign bus.in_ready  = en_p1;
  assign bus.out_valid = vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (en_p1) vld_p1 <= bus.in_valid;
      if (en_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- Stage 1: operand conditioning, bit and group propagate/generate ----
  alu_mode_e        mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic             c0_c;
  logic [NG-1:0]    gp_c;
  logic [NG-1:0]    gg_c;

  assign mode  = alu_mode_e'(bus.sub);
  assign b_eff = (mode == MODE_SUB) ? ~bus.b : bus.b;
  assign c0_c  = (mode == MODE_SUB) ? 1'b1 : bus.cin;
  assign p_c   = bus.a ^ b_eff;
  assign g_c   = bus.a & b_eff;

  always_comb begin
    gp_c = '0;
    gg_c = '0;
    for (int k = 0; k < NG; k++) begin
      {gp_c[k], gg_c[k]} = group_pg(p_c[k*GROUP_W +: GROUP_W], g_c[k*GROUP_W +: GROUP_W]);
    end
  end

  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;
  logic [NG-1:0]    gp_p1;
  logic [NG-1:0]    gg_p1;
  logic             c0_p1;
  logic             amsb_p1;
  logic             bmsb_p1;

  always_ff @(posedge clk) begin
    if (en_p1 && bus.in_valid) begin
      p_p1    <= p_c;
      g_p1    <= g_c;
      gp_p1   <= gp_c;
      gg_p1   <= gg_c;
      c0_p1   <= c0_c;
      amsb_p1 <= bus.a[WIDTH-1];
      bmsb_p1 <= b_eff[WIDTH-1];
    end
  end

  // ---- Stage 2: group carries, in-group carries, sum and flags ----
  logic [NG-1:0]    gc_c;
  logic             gp_all;
  logic             gg_all;
  logic [WIDTH-1:0] c_c;
  logic             cout_c;
  logic [WIDTH-1:0] sum_c;
  logic [NG-1:0]    unused_gp;
  logic [NG-1:0]    unused_gg;

  cla_group #(.W(NG)) u_group_carry (
    .p    (gp_p1),
    .g    (gg_p1),
    .c_in (c0_p1),
    .c    (gc_c),
    .gp   (gp_all),
    .gg   (gg_all)
  );

  for (genvar k = 0; k < NG; k++) begin : g_bit_carry
    cla_group #(.W(GROUP_W)) u_cla (
      .p    (p_p1[k*GROUP_W +: GROUP_W]),
      .g    (g_p1[k*GROUP_W +: GROUP_W]),
      .c_in (gc_c[k]),
      .c    (c_c[k*GROUP_W +: GROUP_W]),
      .gp   (unused_gp[k]),
      .gg   (unused_gg[k])
    );
  end

  // Carry out of the MSB comes straight from the top-level lookahead, so no bit is dropped.
  assign cout_c = gg_all | (gp_all & c0_p1);
  assign sum_c  = p_p1 ^ c_c;

  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2;
  logic             ovf_p2;
  logic             zero_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else if (en_p2 && vld_p1) begin
      sum_p2  <= sum_c;
      cout_p2 <= cout_c;
      ovf_p2  <= signed_ovf(amsb_p1, bmsb_p1, sum_c[WIDTH-1]);
      zero_p2 <= ~|sum_c;
    end
  end

  assign bus.sum  = sum_p2;
  assign bus.cout = cout_p2;
  assign bus.ovf  = ovf_p2;
  assign bus.zero = zero_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: GROUP_W = 4, 2 and 8 instances driven in lockstep.
module tb_pipelined_cla_adder;
  import pipelined_cla_adder_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(W)) if4 ();
  pipelined_cla_adder_if #(.WIDTH(W)) if2 ();
  pipelined_cla_adder_if #(.WIDTH(W)) if8 ();

  pipelined_cla_adder #(.WIDTH(W), .GROUP_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  pipelined_cla_adder #(.WIDTH(W), .GROUP_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  pipelined_cla_adder #(.WIDTH(W), .GROUP_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  assign if2.in_valid  = if4.in_valid;
  assign if2.a         = if4.a;
  assign if2.b         = if4.b;
  assign if2.cin       = if4.cin;
  assign if2.sub       = if4.sub;
  assign if2.out_ready = if4.out_ready;
  assign if8.in_valid  = if4.in_valid;
  assign if8.a         = if4.a;
  assign if8.b         = if4.b;
  assign if8.cin       = if4.cin;
  assign if8.sub       = if4.sub;
  assign if8.out_ready = if4.out_ready;

  res_t obs  [3];
  logic ovld [3];
  logic irdy [3];
  assign obs[0]  = {if4.sum, if4.cout, if4.ovf, if4.zero};
  assign obs[1]  = {if2.sum, if2.cout, if2.ovf, if2.zero};
  assign obs[2]  = {if8.sum, if8.cout, if8.ovf, if8.zero};
  assign ovld[0] = if4.out_valid;
  assign ovld[1] = if2.out_valid;
  assign ovld[2] = if8.out_valid;
  assign irdy[0] = if4.in_ready;
  assign irdy[1] = if2.in_ready;
  assign irdy[2] = if8.in_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic res_t ref_model(input op_t op);
    longint unsigned ua, ub, full;
    longint          sa, sb, sr;
    res_t            r;
    ua = 64'(op.a);
    ub = 64'(op.b);
    sa = longint'($signed(op.a));
    sb = longint'($signed(op.b));
    if (op.sub) begin
      full   = ua - ub;
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      full   = ua + ub + 64'(op.cin);
      r.cout = full[W];
      sr     = sa + sb + longint'(64'(op.cin));
    end
    r.sum  = full[W-1:0];
    r.ovf  = (sr > SMAX) || (sr < SMIN);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("sum=%h cout=%b ovf=%b zero=%b", r.sum, r.cout, r.ovf, r.zero);
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_beat();
    op_t op;
    op.a   = rand_op();
    op.b   = rand_op();
    op.cin = 1'($urandom_range(0, 1));
    op.sub = 1'($urandom_range(0, 1));
    return op;
  endfunction

  task automatic drive(input logic vld, input op_t op);
    if4.in_valid = vld;
    if4.a        = op.a;
    if4.b        = op.b;
    if4.cin      = op.cin;
    if4.sub      = op.sub;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    if4.out_ready = 1'b1;
    drive(1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (irdy[k] !== 1'b1 || ovld[k] !== 1'b0 || obs[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got in_ready=%b out_valid=%b %s, want in_ready=1 out_valid=0 all zero",
                 k, irdy[k], ovld[k], fmt(obs[k]));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (irdy[k] !== 1'b1 || ovld[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: got in_ready=%b out_valid=%b, want 1/0", k, irdy[k], ovld[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    op_t   vec  [7];
    res_t  want [7];
    string name [7];
    vec[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, cin: 1'b0, sub: 1'b0};
    want[0] = '{sum: 32'h0000_0008, cout: 1'b0, ovf: 1'b0, zero: 1'b0}; name[0] = "add_5_3";
    vec[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, sub: 1'b0};
    want[1] = '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}; name[1] = "carry_chain";
    vec[2] = '{a: 32'h0000_0005, b: 32'h0000_0007, cin: 1'b0, sub: 1'b1};
    want[2] = '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0}; name[2] = "sub_borrow";
    vec[3] = '{a: 32'h8000_0000, b: 32'h0000_0001, cin: 1'b0, sub: 1'b1};
    want[3] = '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0}; name[3] = "sub_ovf";
    vec[4] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0};
    want[4] = '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0}; name[4] = "add_ovf";
    vec[5] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0};
    want[5] = '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}; name[5] = "wrap";
    vec[6] = '{a: 32'h0000_0005, b: 32'h0000_0005, cin: 1'b1, sub: 1'b1};
    want[6] = '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}; name[6] = "sub_cin_ignored";
    if4.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vec[i]);
      @(posedge clk);
      #1;
      drive(1'b0, vec[i]);
      n_tests++;
      if (ovld[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_latency: got out_valid=%b one cycle after accept, want 0", name[i], ovld[0]);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (ovld[k] !== 1'b1 || obs[k] !== want[i]) begin
          n_fail++;
          $display("FAIL %s dut%0d: got out_valid=%b %s, want out_valid=1 %s",
                   name[i], k, ovld[k], fmt(obs[k]), fmt(want[i]));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    op_t  beats [4];
    res_t held  [3];
    res_t e;
    logic have_held;
    int   sent, got;
    for (int i = 0; i < 4; i++) begin
      beats[i]     = rand_beat();
      beats[i].sub = 1'(i & 1);
    end
    exp_q.delete();
    sent      = 0;
    got       = 0;
    have_held = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive(sent < 4, beats[(sent < 4) ? sent : 3]);
      if4.out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc == 2) begin
        n_tests++;
        if (irdy[0] !== 1'b0 || sent != 2) begin
          n_fail++;
          $display("FAIL bp_ready_drop: got in_ready=%b after %0d accepted, want 0 after 2", irdy[0], sent);
        end
      end
      if (ovld[0] === 1'b1 && !if4.out_ready) begin
        if (have_held) begin
          for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== held[k] || ovld[k] !== 1'b1) begin
              n_fail++;
              $display("FAIL bp_hold dut%0d: got %s, want %s", k, fmt(obs[k]), fmt(held[k]));
            end
          end
        end
        for (int k = 0; k < 3; k++) held[k] = obs[k];
        have_held = 1'b1;
      end
      if (ovld[0] === 1'b1 && if4.out_ready) begin
        have_held = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_spurious: got an output beat, want none outstanding");
        end else begin
          e = exp_q.pop_front();
          got++;
          for (int k = 0; k < 3; k++) begin
            if (ovld[k] !== 1'b1 || obs[k] !== e) begin
              n_fail++;
              $display("FAIL bp_beat%0d dut%0d: got %s, want %s", got - 1, k, fmt(obs[k]), fmt(e));
            end
          end
        end
      end
      if (if4.in_valid && irdy[0] === 1'b1) begin
        exp_q.push_back(ref_model(beats[sent]));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, '0);
    n_tests++;
    if (got != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_all_out: got %0d beats out (%0d pending), want 4 (0 pending)", got, exp_q.size());
    end
  endtask

  task automatic test_random_stream(input int n_cycles, input string tag);
    op_t  op;
    res_t e;
    int   npop;
    exp_q.delete();
    npop = 0;
    for (int cyc = 0; cyc < n_cycles + 12; cyc++) begin
      op = rand_beat();
      if (cyc < n_cycles) begin
        drive($urandom_range(0, 9) < 7, op);
        if4.out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        drive(1'b0, op);
        if4.out_ready = 1'b1;
      end
      @(negedge clk);
      if (ovld[0] === 1'b1 && if4.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_spurious: got an output beat at cycle %0d, want none outstanding", tag, cyc);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 3; k++) begin
            if (ovld[k] !== 1'b1 || obs[k] !== e) begin
              n_fail++;
              $display("FAIL %s_beat%0d dut%0d: got vld=%b %s, want vld=1 %s",
                       tag, npop, k, ovld[k], fmt(obs[k]), fmt(e));
            end
          end
          npop++;
        end
      end
      if (if4.in_valid && irdy[0] === 1'b1) exp_q.push_back(ref_model(op));
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (exp_q.size() != 0 || npop == 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d beats pending after %0d popped, want 0 pending", tag, exp_q.size(), npop);
    end
  endtask

  task automatic test_reset_midflight();
    op_t op;
    exp_q.delete();
    if4.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op = rand_beat();
      drive(1'b1, op);
      @(posedge clk);
      #1;
    end
    drive(1'b0, op);
    n_tests++;
    if (ovld[0] !== 1'b1 || irdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_setup: got out_valid=%b in_ready=%b, want 1/0", ovld[0], irdy[0]);
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ovld[k] !== 1'b0 || irdy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got out_valid=%b in_ready=%b, want 0/1", k, ovld[k], irdy[k]);
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    if4.out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (ovld[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL no_stale dut%0d cycle %0d: got out_valid=%b, want 0", k, cyc, ovld[k]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    if4.out_ready = 1'b1;
    drive(1'b0, '0);
    test_reset();
    test_directed();
    test_backpressure();
    test_random_stream(400, "stream");
    test_reset_midflight();
    test_random_stream(100, "post_reset");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
